// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and divider state encoding.
package alu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the partial
// remainder and keep the difference only when it does not go negative.
module div_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   // partial - divisor as partial + ~{0,divisor} + 1. Because the partial
   // remainder is always below 2*divisor, the difference fits in WIDTH+1
   // signed bits, so its top bit is exactly the borrow.
   logic [WIDTH:0] trial;

   assign trial    = partial + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
   assign q_bit    = ~trial[WIDTH];
   // A kept difference is below the divisor, and a restored partial is too,
   // so dropping the top bit never loses information.
   assign rem_next = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock with a
// start/busy/done handshake. Divide-by-zero finishes immediately.
module seq_divider
   import alu_pkg::*;
#(
   parameter  int WIDTH = DATA_W,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] rem_r, rem_n;     // running partial remainder
   logic [WIDTH-1:0] shift_r, shift_n; // dividend bits out of the top, quotient bits in at the bottom
   logic [WIDTH-1:0] dvsr_r, dvsr_n;
   logic             busy_n, done_n, dbz_n;
   logic [WIDTH-1:0] quo_n, remd_n;

   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             last_step;

   div_step #(.WIDTH(WIDTH)) u_step (
      .partial  ({rem_r, shift_r[WIDTH-1]}),
      .divisor  (dvsr_r),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // Next-state and next-output decode; everything is registered below so
   // no input reaches an output combinationally.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rem_n   = rem_r;
      shift_n = shift_r;
      dvsr_n  = dvsr_r;
      busy_n  = busy;
      done_n  = 1'b0;
      dbz_n   = 1'b0;
      quo_n   = quotient;
      remd_n  = remainder;
      case (state)
         RUN: begin
            rem_n   = step_rem;
            shift_n = {shift_r[WIDTH-2:0], step_q};
            cnt_n   = cnt + CNT_W'(1);
            if (last_step) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               quo_n   = {shift_r[WIDTH-2:0], step_q};
               remd_n  = step_rem;
            end
         end
         default: begin
            // IDLE and DONE accept a new request identically, which is what
            // allows back-to-back divisions without a dead cycle.
            state_n = IDLE;
            busy_n  = 1'b0;
            if (start) begin
               if (divisor != '0) begin
                  state_n = RUN;
                  busy_n  = 1'b1;
                  rem_n   = '0;
                  shift_n = dividend;
                  dvsr_n  = divisor;
                  cnt_n   = '0;
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  dbz_n   = 1'b1;
                  quo_n   = '1;
                  remd_n  = dividend;
               end
            end
         end
      endcase
   end

   // State, datapath and output registers; reset discards any partial result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_r       <= '0;
         shift_r     <= '0;
         dvsr_r      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         rem_r       <= rem_n;
         shift_r     <= shift_n;
         dvsr_r      <= dvsr_n;
         busy        <= busy_n;
         done        <= done_n;
         div_by_zero <= dbz_n;
         quotient    <= quo_n;
         remainder   <= remd_n;
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases with literal answers,
// then randomized divisions against a countdown model using / and %.
module tb_seq_divider;

   localparam int W      = 32;
   localparam int N_RAND = 1000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  dividend = '0;
   logic [W-1:0]  divisor = '0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  quotient, remainder;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: a request is a countdown of W edges ending in a
   // one-cycle done carrying a/b and a%b; a zero divisor answers at once.
   logic [W-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0, p_q = '0, p_r = '0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   bit           running = 1'b0;
   int           left = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
         running = 1'b0; left = 0;
      end else begin
         m_done = 1'b0;
         m_dbz  = 1'b0;
         if (running) begin
            left--;
            if (left == 0) begin
               running = 1'b0; m_busy = 1'b0; m_done = 1'b1;
               m_q = p_q; m_r = p_r;
            end
         end else if (start) begin
            m_a = dividend; m_b = divisor;
            if (divisor != '0) begin
               running = 1'b1; left = W; m_busy = 1'b1;
               p_q = dividend / divisor; p_r = dividend % divisor;
            end else begin
               m_done = 1'b1; m_dbz = 1'b1; m_q = '1; m_r = dividend;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("div_by_zero", div_by_zero, m_dbz);
         chk("quotient", quotient, m_q);
         chk("remainder", remainder, m_r);
         chk("done_and_busy", done & busy, 1'b0);
         if (m_done && !m_dbz) begin
            chk("q*d+r", 64'(quotient) * 64'(m_b) + 64'(remainder), 64'(m_a));
            chk("r_lt_d", remainder < m_b, 1'b1);
         end
      end
   end

   // Present a request for exactly one rising edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // lat = number of edges after the start edge before done shows.
   task automatic wait_done(output int lat, output bit saw_busy);
      lat = 0; saw_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
         if (done === 1'b1) break;
         lat++;
         if (lat > 100) begin
            chk("done_timeout", 1'b0, 1'b1);
            break;
         end
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edbz, input int elat, input string nm);
      int lat; bit sb;
      start_op(a, b);
      wait_done(lat, sb);
      chk({nm, "_q"}, quotient, eq);
      chk({nm, "_r"}, remainder, er);
      chk({nm, "_dbz"}, div_by_zero, edbz);
      chk({nm, "_lat"}, lat, elat);
      if (edbz) chk({nm, "_busy_seen"}, sb, 1'b0);
   endtask

   initial begin
      int lat; bit sb;
      logic [W-1:0] a, b;
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", quotient, '0);
      chk("rst_r", remainder, '0);
      chk("rst_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      cmp_en = 1'b1;
      @(negedge clk);

      do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W, "d100_7");
      @(negedge clk);
      do_op(32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, W, "top_bit");
      do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W, "by_one");
      @(negedge clk);
      do_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, W, "small");
      @(negedge clk);
      do_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, "zero");
      @(negedge clk); @(negedge clk);

      // A start pulse mid-run must be ignored.
      start_op(32'd84, 32'd4);
      repeat (9) @(negedge clk);
      start_op(32'd9, 32'd3);
      wait_done(lat, sb);
      chk("ignore_q", quotient, 32'd21);
      chk("ignore_r", remainder, 32'd0);
      chk("ignore_lat", lat, 23);
      // Back-to-back: request issued during the DONE cycle.
      do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, W, "b2b");
      @(negedge clk); @(negedge clk);

      // Asynchronous reset in the middle of a run.
      start_op(32'd1000, 32'd9);
      repeat (15) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_q", quotient, '0);
      chk("mid_rst_r", remainder, '0);
      chk("mid_rst_dbz", div_by_zero, 1'b0);
      @(negedge clk); @(negedge clk);
      #2 reset = 1'b0;
      repeat (40) @(negedge clk);
      do_op(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, W, "after_rst");

      // Randomized operands, mixing magnitudes, zero divisors and back-to-back issue.
      for (int i = 0; i < N_RAND; i++) begin
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = W'($urandom_range(1, 255));
            2:       b = 32'h8000_0000 | W'($urandom);
            3:       b = W'($urandom) >> $urandom_range(0, 31);
            default: b = W'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) a = W'($urandom) >> $urandom_range(0, 31);
         else a = W'($urandom);
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         start_op(a, b);
         wait_done(lat, sb);
         chk("rand_lat", lat, (b == '0) ? 0 : W);
      end
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
